// File: rtl/xilinx_rst_sequencer.sv
// Reset sequencer for the FPGA top level: waits for clock lock and DRAM calibration,
// holds the Ethernet PHY in reset for a fixed time, then releases the SoC and latches boot mode.
module xilinx_rst_sequencer #(
    parameter int unsigned EthRstCycles       = 500000,
    parameter int unsigned SettleCycles       = 16,
    parameter int unsigned CalibTimeoutCycles = 2**24,
    parameter bit          UseDdr             = 1'b1,
    parameter int unsigned CntWidth           = 24
) (
    input  logic       soc_clk,
    input  logic       rst_n,
    input  logic       clk_locked_i,
    input  logic       calib_done_i,
    input  logic       sw_rst_i,
    input  logic [1:0] boot_mode_i,
    output logic       soc_rst_no,
    output logic       eth_rst_no,
    output logic [1:0] boot_mode_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_LOCK   = 3'd0,
        S_CALIB  = 3'd1,
        S_PHY    = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4,
        S_FAULT  = 3'd5
    } state_e;

    // Counter reload values: a state lasting N cycles is entered with N-1.
    localparam logic [CntWidth-1:0] CalibLoad  = CntWidth'(CalibTimeoutCycles - 1);
    localparam logic [CntWidth-1:0] EthLoad    = CntWidth'(EthRstCycles - 1);
    localparam logic [CntWidth-1:0] SettleLoad = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);

    state_e               state_q, state_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic                 lock_meta_q, lock_meta_d;
    logic                 lock_sync_q, lock_sync_d;
    logic                 calib_meta_q, calib_meta_d;
    logic                 calib_sync_q, calib_sync_d;
    logic                 soc_rst_n_q, soc_rst_n_d;
    logic                 eth_rst_n_q, eth_rst_n_d;
    logic [1:0]           boot_mode_q, boot_mode_d;
    logic                 fault_q, fault_d;
    logic                 lock_s;
    logic                 calib_s;

    always_comb begin
        lock_meta_d  = clk_locked_i;
        lock_sync_d  = lock_meta_q;
        calib_meta_d = calib_done_i;
        calib_sync_d = calib_meta_q;
    end

    // Without DRAM the calibration condition is permanently satisfied.
    assign lock_s  = lock_sync_q;
    assign calib_s = UseDdr ? calib_sync_q : 1'b1;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_LOCK: begin
                if (lock_s && !sw_rst_i) state_d = S_CALIB;
            end
            S_CALIB: begin
                if (sw_rst_i || !lock_s) state_d = S_LOCK;
                else if (calib_s)        state_d = S_PHY;
                else if (cnt_q == '0)    state_d = S_FAULT;
            end
            S_PHY: begin
                if (sw_rst_i || !lock_s) state_d = S_LOCK;
                else if (cnt_q == '0)    state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (sw_rst_i || !lock_s) state_d = S_LOCK;
                else if (cnt_q == '0)    state_d = S_RUN;
            end
            S_RUN: begin
                if (sw_rst_i || !lock_s) state_d = S_LOCK;
                else if (!calib_s)       state_d = S_FAULT;
            end
            S_FAULT: begin
                if (sw_rst_i) state_d = S_LOCK;
            end
            default: state_d = S_LOCK;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            unique case (state_d)
                S_CALIB:  cnt_d = CalibLoad;
                S_PHY:    cnt_d = EthLoad;
                S_SETTLE: cnt_d = SettleLoad;
                default:  cnt_d = '0;
            endcase
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntOne;
        end
    end

    // Outputs decode the next state so they flip on the same edge as state_o.
    always_comb begin
        soc_rst_n_d = (state_d == S_RUN);
        eth_rst_n_d = (state_d == S_SETTLE) || (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
        boot_mode_d = boot_mode_q;
        if ((state_q == S_SETTLE) && (state_d == S_RUN)) boot_mode_d = boot_mode_i;
    end

    always_ff @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_LOCK;
            cnt_q        <= '0;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            calib_meta_q <= 1'b0;
            calib_sync_q <= 1'b0;
            soc_rst_n_q  <= 1'b0;
            eth_rst_n_q  <= 1'b0;
            boot_mode_q  <= 2'b00;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lock_meta_q  <= lock_meta_d;
            lock_sync_q  <= lock_sync_d;
            calib_meta_q <= calib_meta_d;
            calib_sync_q <= calib_sync_d;
            soc_rst_n_q  <= soc_rst_n_d;
            eth_rst_n_q  <= eth_rst_n_d;
            boot_mode_q  <= boot_mode_d;
            fault_q      <= fault_d;
        end
    end

    assign soc_rst_no  = soc_rst_n_q;
    assign eth_rst_no  = eth_rst_n_q;
    assign boot_mode_o = boot_mode_q;
    assign fault_o     = fault_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_xilinx_rst_sequencer.sv
// Bench for xilinx_rst_sequencer: directed timing scenarios plus random input traffic,
// compared every cycle against a phase/elapsed-time reference model for DDR and no-DDR builds.
module tb_xilinx_rst_sequencer;

    localparam int ETH = 8;
    localparam int SET = 4;
    localparam int CAL = 64;
    localparam int S_LOCK = 0, S_CALIB = 1, S_PHY = 2, S_SETTLE = 3, S_RUN = 4, S_FAULT = 5;

    logic       soc_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_locked_i = 1'b0;
    logic       calib_done_i = 1'b0;
    logic       sw_rst_i = 1'b0;
    logic [1:0] boot_mode_i = 2'b00;

    logic       soc0, eth0, fault0, soc1, eth1, fault1;
    logic [1:0] boot0, boot1;
    logic [2:0] state0, state1;

    int n_checks = 0;
    int n_errors = 0;
    int edge_n = 0;

    xilinx_rst_sequencer #(
        .EthRstCycles(ETH), .SettleCycles(SET), .CalibTimeoutCycles(CAL),
        .UseDdr(1'b1), .CntWidth(24)
    ) dut (
        .soc_clk(soc_clk), .rst_n(rst_n), .clk_locked_i(clk_locked_i),
        .calib_done_i(calib_done_i), .sw_rst_i(sw_rst_i), .boot_mode_i(boot_mode_i),
        .soc_rst_no(soc0), .eth_rst_no(eth0), .boot_mode_o(boot0),
        .fault_o(fault0), .state_o(state0)
    );

    xilinx_rst_sequencer #(
        .EthRstCycles(ETH), .SettleCycles(SET), .CalibTimeoutCycles(CAL),
        .UseDdr(1'b0), .CntWidth(24)
    ) dut_nd (
        .soc_clk(soc_clk), .rst_n(rst_n), .clk_locked_i(clk_locked_i),
        .calib_done_i(calib_done_i), .sw_rst_i(sw_rst_i), .boot_mode_i(boot_mode_i),
        .soc_rst_no(soc1), .eth_rst_no(eth1), .boot_mode_o(boot1),
        .fault_o(fault1), .state_o(state1)
    );

    // Clock and edge numbering (edge 1 is the first rising edge after rst_n release).
    always #5 soc_clk = ~soc_clk;

    always @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) edge_n <= 0;
        else        edge_n <= edge_n + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: each build sits in a phase with a known entry cycle; a timed phase
    // ends once it has lasted its full duration. Inputs are seen two clocks late.
    int         m_ph[2] = '{0, 0};
    int         m_entry[2] = '{0, 0};
    int         m_nx[2];
    logic [1:0] m_boot[2] = '{2'b00, 2'b00};
    int         m_cyc = 0;
    logic       m_l1 = 1'b0, m_l2 = 1'b0, m_c1 = 1'b0, m_c2 = 1'b0;

    function automatic int phase_len(input int ph);
        int len;
        case (ph)
            S_CALIB:  len = CAL;
            S_PHY:    len = ETH;
            S_SETTLE: len = SET;
            default:  len = 0;
        endcase
        return len;
    endfunction

    function automatic int next_phase(input int ph, input int elapsed, input logic ls,
                                      input logic cs, input logic sw);
        int   nx;
        logic done;
        nx = ph;
        done = (elapsed + 1 >= phase_len(ph));
        if (ph == S_LOCK) begin
            if (ls && !sw) nx = S_CALIB;
        end else if (ph == S_FAULT) begin
            if (sw) nx = S_LOCK;
        end else if (sw || !ls) begin
            nx = S_LOCK;
        end else begin
            case (ph)
                S_CALIB:  nx = cs ? S_PHY : (done ? S_FAULT : S_CALIB);
                S_PHY:    nx = done ? S_SETTLE : S_PHY;
                S_SETTLE: nx = done ? S_RUN : S_SETTLE;
                S_RUN:    nx = cs ? S_RUN : S_FAULT;
                default:  nx = S_LOCK;
            endcase
        end
        return nx;
    endfunction

    always_comb begin
        m_nx[0] = next_phase(m_ph[0], m_cyc - m_entry[0], m_l2, m_c2, sw_rst_i);
        m_nx[1] = next_phase(m_ph[1], m_cyc - m_entry[1], m_l2, 1'b1, sw_rst_i);
    end

    always @(posedge soc_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc <= 0;
            m_l1 <= 1'b0; m_l2 <= 1'b0; m_c1 <= 1'b0; m_c2 <= 1'b0;
            for (int k = 0; k < 2; k++) begin
                m_ph[k] <= S_LOCK; m_entry[k] <= 0; m_boot[k] <= 2'b00;
            end
        end else begin
            m_cyc <= m_cyc + 1;
            m_l1 <= clk_locked_i; m_l2 <= m_l1;
            m_c1 <= calib_done_i; m_c2 <= m_c1;
            for (int k = 0; k < 2; k++) begin
                if (m_nx[k] != m_ph[k]) begin
                    m_ph[k] <= m_nx[k];
                    m_entry[k] <= m_cyc + 1;
                end
                if (m_ph[k] == S_SETTLE && m_nx[k] == S_RUN) m_boot[k] <= boot_mode_i;
            end
        end
    end

    // Scoreboard: every cycle both builds are compared against the model.
    always @(negedge soc_clk) begin
        check_eq("state",     state0, m_ph[0]);
        check_eq("soc_rst",   soc0,   m_ph[0] == S_RUN);
        check_eq("eth_rst",   eth0,   m_ph[0] == S_SETTLE || m_ph[0] == S_RUN);
        check_eq("fault",     fault0, m_ph[0] == S_FAULT);
        check_eq("boot",      boot0,  m_boot[0]);
        check_eq("nd_state",  state1, m_ph[1]);
        check_eq("nd_soc",    soc1,   m_ph[1] == S_RUN);
        check_eq("nd_eth",    eth1,   m_ph[1] == S_SETTLE || m_ph[1] == S_RUN);
        check_eq("nd_fault",  fault1, m_ph[1] == S_FAULT);
        check_eq("nd_boot",   boot1,  m_boot[1]);
    end

    // Driver tasks: inputs change 2 time units after a rising edge; directed checks
    // sample 1 time unit after a rising edge.
    task automatic at_edge(input int n);
        int guard = 0;
        while (edge_n < n && guard < 1000) begin
            @(posedge soc_clk); #1;
            guard++;
        end
    endtask

    task automatic do_reset();
        @(posedge soc_clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge soc_clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic wait_state(input int st, input int budget, input string tag);
        int n = 0;
        while (int'(state0) != st && n < budget) begin
            @(posedge soc_clk); #1;
            n++;
        end
        check_eq(tag, state0, st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish by 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_cal, n_phy, n_set, r;

        // Nominal power-up.
        clk_locked_i = 1'b1; calib_done_i = 1'b1; boot_mode_i = 2'b10;
        repeat (3) @(posedge soc_clk);
        #1; check_eq("reset_soc", soc0, 0); check_eq("reset_state", state0, S_LOCK);
        #1; rst_n = 1'b1;
        at_edge(2);  check_eq("nom_e2_state", state0, S_LOCK);
        at_edge(3);  check_eq("nom_e3_state", state0, S_CALIB);
        at_edge(4);  check_eq("nom_e4_state", state0, S_PHY);
        at_edge(11); check_eq("nom_e11_eth", eth0, 0);
        at_edge(12); check_eq("nom_e12_eth", eth0, 1);
        at_edge(15); check_eq("nom_e15_soc", soc0, 0);
        at_edge(16); check_eq("nom_e16_soc", soc0, 1);
        check_eq("nom_boot", boot0, 2'b10);
        check_eq("nd_nom_e16_soc", soc1, 1);
        #1; boot_mode_i = 2'b01;
        at_edge(22); check_eq("nom_boot_frozen", boot0, 2'b10);

        // Calibration timeout; the no-DDR build ignores calib and runs normally.
        calib_done_i = 1'b0;
        do_reset();
        n_cal = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge soc_clk); #1;
            if (state0 == 3'(S_CALIB)) n_cal++;
            if (edge_n == 16) check_eq("nd_nocalib_e16_soc", soc1, 1);
            if (state0 == 3'(S_FAULT)) break;
        end
        check_eq("to_calib_cycles", n_cal, CAL);
        check_eq("to_state", state0, S_FAULT);
        check_eq("to_fault", fault0, 1);
        check_eq("to_soc", soc0, 0);
        #1; sw_rst_i = 1'b1;
        @(posedge soc_clk); #1;
        check_eq("to_sw_state", state0, S_LOCK);
        check_eq("to_sw_fault", fault0, 0);
        #1; sw_rst_i = 1'b0; calib_done_i = 1'b1;
        wait_state(S_RUN, 100, "to_recover_run");
        check_eq("to_recover_fault", fault0, 0);

        // Calib arrives exactly in the last S_CALIB cycle.
        calib_done_i = 1'b0; boot_mode_i = 2'b11;
        do_reset();
        at_edge(64); #1; calib_done_i = 1'b1;
        at_edge(66); check_eq("bnd_e66_state", state0, S_CALIB);
        at_edge(67); check_eq("bnd_e67_state", state0, S_PHY);
        check_eq("bnd_fault", fault0, 0);
        at_edge(79); check_eq("bnd_e79_soc", soc0, 1);
        check_eq("bnd_boot", boot0, 2'b11);

        // Lock loss in S_RUN, then relock.
        at_edge(80); #1; clk_locked_i = 1'b0;
        at_edge(82); check_eq("ll_e82_soc", soc0, 1);
        at_edge(83); check_eq("ll_e83_soc", soc0, 0);
        check_eq("ll_e83_eth", eth0, 0);
        check_eq("ll_e83_state", state0, S_LOCK);
        #1; clk_locked_i = 1'b1;
        n_phy = 0; n_set = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge soc_clk); #1;
            if (state0 == 3'(S_PHY)) n_phy++;
            if (state0 == 3'(S_SETTLE)) n_set++;
            if (state0 == 3'(S_RUN)) break;
        end
        check_eq("ll_phy_cycles", n_phy, ETH);
        check_eq("ll_settle_cycles", n_set, SET);
        check_eq("ll_run", state0, S_RUN);

        // sw_rst_i and calib loss in the same cycle: reset request wins.
        at_edge(100); #1; calib_done_i = 1'b0;
        at_edge(102); check_eq("sim_e102_state", state0, S_RUN);
        #1; sw_rst_i = 1'b1;
        at_edge(103); check_eq("sim_state", state0, S_LOCK);
        check_eq("sim_fault", fault0, 0);
        check_eq("nd_sim_state", state1, S_LOCK);
        at_edge(104); #1; sw_rst_i = 1'b0; calib_done_i = 1'b1;

        // Asynchronous reset in the middle of S_PHY.
        wait_state(S_PHY, 50, "ar_reach_phy");
        #1; rst_n = 1'b0;
        #1;
        check_eq("ar_state", state0, S_LOCK);
        check_eq("ar_soc", soc0, 0);
        check_eq("ar_eth", eth0, 0);
        check_eq("ar_fault", fault0, 0);
        check_eq("ar_boot", boot0, 0);
        rst_n = 1'b1;
        at_edge(3);  check_eq("ar_e3_state", state0, S_CALIB);
        at_edge(16); check_eq("ar_e16_soc", soc0, 1);

        // Random traffic, checked by the scoreboard each cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge soc_clk); #2;
            r = $urandom_range(0, 999);
            if (r < 5)       clk_locked_i = ~clk_locked_i;
            else if (r < 10) calib_done_i = ~calib_done_i;
            sw_rst_i = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 19) == 0) boot_mode_i = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0; #1; rst_n = 1'b1;
            end
        end

        repeat (2) @(posedge soc_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
